// File: rtl/regfile_dump_tx.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_tx
// Purpose  : Debug reader for the 32x32-bit register file. A start request
//            walks every register through a dedicated read port, captures
//            the 32-bit value and streams it out as bytes on a valid/ready
//            byte interface (UART or trace sink).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_REGS   registers dumped, indices 0..NUM_REGS-1 (1..32)
//   LSB_FIRST  1: byte [7:0] sent first, 0: byte [31:24] sent first
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   DumpStart  start request, honoured only while idle
//   DumpRs     register-file read address (registered)
//   DumpData   combinational register-file read data for DumpRs
//   TxData     current byte
//   TxValid    byte available
//   TxReady    sink accepts (transfer on TxValid && TxReady)
//   DumpBusy   high whenever a dump is in progress
//   DumpDone   one-cycle pulse after the last byte is accepted
// Build option:
//   DUMP_INDEX_HDR_EN  when defined, each register is preceded by one
//                      index byte {3'b000, idx}
// ============================================================================
module regfile_dump_tx #(
    parameter int NUM_REGS  = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DumpStart,
    output logic [4:0]  DumpRs,
    input  logic [31:0] DumpData,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        DumpBusy,
    output logic        DumpDone
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
`ifdef DUMP_INDEX_HDR_EN
        S_HDR  = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] c_last_idx = 5'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q,   idx_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q,   cnt_d;

    logic [7:0]  w_cur_byte;
    logic [31:0] w_shift_nxt;

    // The outgoing byte always sits at one end of the shift register; each
    // accepted byte shifts the next one into that position.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_cur_byte  = shift_q[7:0];
            assign w_shift_nxt = {8'h00, shift_q[31:8]};
        end else begin : g_msb_first
            assign w_cur_byte  = shift_q[31:24];
            assign w_shift_nxt = {shift_q[23:0], 8'h00};
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        TxData   = 8'h00;
        TxValid  = 1'b0;
        DumpBusy = 1'b1;
        DumpDone = 1'b0;

        case (state_q)
            S_IDLE: begin
                DumpBusy = 1'b0;
                if (DumpStart) begin
                    idx_d   = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Capture happens only here, so later writes to this
                // register do not affect the bytes already in flight.
                shift_d = DumpData;
                cnt_d   = 2'd0;
`ifdef DUMP_INDEX_HDR_EN
                state_d = S_HDR;
`else
                state_d = S_SEND;
`endif
            end
`ifdef DUMP_INDEX_HDR_EN
            S_HDR: begin
                TxValid = 1'b1;
                TxData  = {3'b000, idx_q};
                if (TxReady) begin
                    state_d = S_SEND;
                end
            end
`endif
            S_SEND: begin
                TxValid = 1'b1;
                TxData  = w_cur_byte;
                if (TxReady) begin
                    shift_d = w_shift_nxt;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // End test precedes the increment, so idx never wraps.
                        if (idx_q == c_last_idx) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                DumpDone = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DumpRs = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_tx
// Purpose  : Self-checking bench for regfile_dump_tx. Two instances (LSB and
//            MSB first) share stimulus and a behavioural register file; the
//            expected byte stream is derived from a per-dump snapshot of the
//            register contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_tx;

    localparam int NREG = 32;
`ifdef DUMP_INDEX_HDR_EN
    localparam int BPR = 5;
`else
    localparam int BPR = 4;
`endif
    localparam int CPR = BPR + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [4:0]  rs_l, rs_m;
    logic [31:0] dd_l, dd_m;
    logic [7:0]  data_l, data_m;
    logic        valid_l, valid_m, busy_l, busy_m, done_l, done_m;

    logic [31:0] rf   [NREG];
    logic [31:0] snap [NREG];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dd_l = rf[rs_l];
    assign dd_m = rf[rs_m];

    regfile_dump_tx #(.NUM_REGS(NREG), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .DumpStart(start), .DumpRs(rs_l),
        .DumpData(dd_l), .TxData(data_l), .TxValid(valid_l), .TxReady(ready),
        .DumpBusy(busy_l), .DumpDone(done_l)
    );

    regfile_dump_tx #(.NUM_REGS(NREG), .LSB_FIRST(1'b0)) u_msb (
        .CLK(clk), .RST_N(rst_n), .DumpStart(start), .DumpRs(rs_m),
        .DumpData(dd_m), .TxData(data_m), .TxValid(valid_m), .TxReady(ready),
        .DumpBusy(busy_m), .DumpDone(done_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte number n of the whole dump, from the snapshot.
    function automatic logic [7:0] exp_byte(input int n, input bit lsb);
        int r, p;
        logic [31:0] v;
        r = n / BPR;
        p = n % BPR;
        v = snap[r];
        if (BPR == 5) begin
            if (p == 0) return 8'(r);
            p = p - 1;
        end
        return lsb ? v[8*p +: 8] : v[8*(3-p) +: 8];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_rs_l"},    32'(rs_l),    32'd0);
        chk({tag, "_data_l"},  32'(data_l),  32'd0);
        chk({tag, "_data_m"},  32'(data_m),  32'd0);
        chk({tag, "_valid_l"}, 32'(valid_l), 32'd0);
        chk({tag, "_valid_m"}, 32'(valid_m), 32'd0);
        chk({tag, "_busy_l"},  32'(busy_l),  32'd0);
        chk({tag, "_done_l"},  32'(done_l),  32'd0);
        chk({tag, "_done_m"},  32'(done_m),  32'd0);
    endtask

    task automatic preload_fixed();
        for (int r = 0; r < NREG; r++) rf[r] = 32'h11 * r + 32'h01020304;
    endtask

    // One complete dump. wr_at: byte count at which RU[31] and RU[2] are
    // rewritten and DumpStart is re-pulsed. abort_at: byte count at which
    // reset is asserted. start_in_done: pulse DumpStart in the DONE cycle.
    task automatic run_dump(input bit rand_ready, input int wr_at,
                            input int abort_at, input bit start_in_done);
        int  n, c, stalls, exp_done;
        bit  done_seen, prev_stall, wrote;
        logic [7:0] prev_l, prev_m;
        n = 0; c = 0; stalls = 0; exp_done = 0;
        done_seen = 1'b0; prev_stall = 1'b0; wrote = 1'b0;
        prev_l = 8'h00; prev_m = 8'h00;
        for (int r = 0; r < NREG; r++) snap[r] = rf[r];

        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        chk("load_busy",  32'(busy_l),  32'd1);
        chk("load_valid", 32'(valid_l), 32'd0);
        chk("load_rs",    32'(rs_l),    32'd0);

        while (!done_seen && c < 4000) begin
            exp_done = 1 + CPR * NREG + stalls;
            start = 1'b0;
            if (abort_at >= 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_quiet("abort");
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_nodone_l", 32'(done_l), 32'd0);
                    chk("abort_nodone_m", 32'(done_m), 32'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (wr_at >= 0 && n == wr_at && !wrote) begin
                wrote  = 1'b1;
                rf[31] = 32'hDEADBEEF;
                rf[2]  = ~rf[2];
                for (int r = n / BPR + 1; r < NREG; r++) snap[r] = rf[r];
                start = 1'b1;
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == exp_done) begin
                done_seen = 1'b1;
                start     = start_in_done;
                chk("byte_total", 32'(n), 32'(BPR * NREG));
                chk("done_valid", 32'(valid_l), 32'd0);
            end
            chk("busy_l", 32'(busy_l), 32'd1);
            chk("busy_m", 32'(busy_m), 32'd1);
            chk("done_l", 32'(done_l), 32'(c == exp_done));
            chk("done_m", 32'(done_m), 32'(c == exp_done));
            if (prev_stall) begin
                chk("hold_valid_l", 32'(valid_l), 32'd1);
                chk("hold_valid_m", 32'(valid_m), 32'd1);
                chk("hold_data_l",  32'(data_l),  32'(prev_l));
                chk("hold_data_m",  32'(data_m),  32'(prev_m));
            end
            if (valid_l && ready) begin
                chk("byte_l",  32'(data_l),  32'(exp_byte(n, 1'b1)));
                chk("byte_m",  32'(data_m),  32'(exp_byte(n, 1'b0)));
                chk("valid_m", 32'(valid_m), 32'd1);
                n++;
            end else if (valid_l) begin
                stalls++;
            end
            prev_stall = valid_l && !ready;
            prev_l     = data_l;
            prev_m     = data_m;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done_reached", 32'(done_seen), 32'd1);
        repeat (3) begin
            chk("idle_busy_l",  32'(busy_l),  32'd0);
            chk("idle_busy_m",  32'(busy_m),  32'd0);
            chk("idle_valid_l", 32'(valid_l), 32'd0);
            chk("idle_done_l",  32'(done_l),  32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        preload_fixed();
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed preload, sink always ready, DumpStart repeated in DONE.
        run_dump(1'b0, -1, -1, 1'b1);

        // Same data under random back-pressure.
        run_dump(1'b1, -1, -1, 1'b0);

        // Writes while idx=5 plus a mid-dump start pulse.
        preload_fixed();
        run_dump(1'b0, BPR * 5 + 1, -1, 1'b0);

        // Random data, reset while sending register 10, then a full dump.
        for (int r = 0; r < NREG; r++) rf[r] = $urandom;
        rf[0] = 32'd0;
        run_dump(1'b0, -1, BPR * 10 + 2, 1'b0);
        chk_quiet("post_abort");
        run_dump(1'b1, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_dump_tx.md
# regfile_dump_tx

Debug reader for the processor's 32×32-bit register file. On a start pulse it walks register addresses through a dedicated read port, captures each 32-bit value, and streams it out as bytes over a valid/ready byte interface, for a UART or trace sink to drain. It sits beside the register file, driving its third read-port address and consuming that port's data. It replaces simulation-only console dumps with a synthesizable path.

## Interface
Parameters:
- NUM_REGS, 32: registers dumped, indices 0..NUM_REGS-1 (1..32).
- LSB_FIRST, 1: 1 sends byte [7:0] first; 0 sends byte [31:24] first.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- DumpStart  in  1  start request; sampled only in IDLE.
- DumpRs  out  5  register-file read address, registered.
- DumpData  in  32  combinational register-file read data for DumpRs.
- TxData  out  8  current byte.
- TxValid  out  1  byte available.
- TxReady  in  1  sink accepts; a transfer occurs on a cycle with TxValid && TxReady.
- DumpBusy  out  1  high in any state other than IDLE.
- DumpDone  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States:
  - IDLE: DumpStart=1 moves to LOAD with idx=0. DumpStart is ignored in every other state.
  - LOAD (1 cycle): DumpRs=idx. At the end of the cycle, shift register ← DumpData and byte count ← 0. Next state is SEND, or HDR when DUMP_INDEX_HDR_EN is defined.
  - HDR: TxValid=1, TxData={3'b000, idx}. On transfer, go to SEND.
  - SEND: TxValid=1, TxData is the current byte in LSB_FIRST order. Each transfer advances the byte count.
    - After the 4th transfer with idx<NUM_REGS-1: idx++ and go to LOAD.
    - After the 4th transfer with idx=NUM_REGS-1: go to DONE.
  - DONE (1 cycle): DumpDone=1, then IDLE.
- Handshake:
  - TxValid, once high, stays high until the transfer.
  - TxData is held stable while TxValid=1 and TxReady=0.
  - No combinational path from TxReady to TxValid or TxData.
- Snapshot: each register is captured only in its own LOAD cycle. Register-file writes during a dump are visible for registers not yet captured and invisible for captured ones.
- Register x0 is dumped like any other register and reads 0.
- Counters: idx is 5 bits, byte count is 2 bits. idx never wraps, because the end condition is checked before increment.
- Reset mid-dump aborts immediately: no DumpDone, and the next dump restarts at idx 0.

## Timing
- Reset values: DumpRs=0, TxData=0, TxValid=0, DumpBusy=0, DumpDone=0, state IDLE.
- With DumpStart sampled high at edge t:
  - LOAD occupies cycle t+1.
  - First TxValid is in cycle t+2.
- With TxReady held at 1:
  - Each register costs 5 cycles without the header, 6 with it.
  - DumpDone is high in cycle t+1+5·NUM_REGS (t+161), or t+1+6·NUM_REGS (t+193) with the header.
  - DumpBusy is high from t+1 through the DumpDone cycle inclusive.
- Stalls (TxReady=0) extend the dump one cycle per stalled cycle. They never drop or duplicate a byte.
- DumpStart asserted in the DONE cycle is ignored. A new dump needs DumpStart while in IDLE.

## Configuration
- DUMP_INDEX_HDR_EN:
  - Defined: the HDR state is present, and each register is preceded by one index byte {3'b000, idx}, giving 5 bytes per register.
  - Undefined: HDR is not compiled, giving 4 bytes per register with no framing.

## Test plan
- Registers preloaded with RU[i]=0x11·i+0x01020304, TxReady=1, LSB_FIRST=1, 1-cycle DumpStart. Expect:
  - first bytes 04 03 02 01;
  - 128 bytes total;
  - DumpDone only in cycle t+161.
- Same preload with LSB_FIRST=0. Expect register 1 bytes 01 02 03 15.
- Random TxReady (≈50% low). Expect:
  - byte stream identical to the first test;
  - TxData stable during every stalled cycle;
  - TxValid never drops before a transfer.
- DUMP_INDEX_HDR_EN defined. Expect:
  - 160 bytes;
  - register 31 framed as 1F then its 4 data bytes;
  - DumpDone at t+193.
- Write RU[31]=0xDEADBEEF while idx=5, and DumpStart pulsed mid-dump. Expect:
  - register 31 streams EF BE AD DE;
  - no restart.
- RST_N low while in SEND at idx=10. Expect:
  - all outputs 0 asynchronously, no DumpDone;
  - the following dump begins with register 0.
